// File: rtl/add_arbiter.sv
// add_arbiter: shares one valid/ready adder among NUM_REQ requesters and routes results back in issue order.
// Build macro ADD_ARB_PRIO_EN selects fixed-priority grant (lowest index wins) instead of round-robin.
module add_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 32,
    parameter int TAG_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_vld,
    output logic [NUM_REQ-1:0]       req_rdy,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    output logic                     add_a_vld,
    output logic                     add_b_vld,
    input  logic                     add_a_rdy,
    input  logic                     add_b_rdy,
    input  logic [WIDTH-1:0]         add_c,
    input  logic                     add_c_vld,
    output logic                     add_c_rdy,
    output logic [WIDTH-1:0]         rsp_c,
    output logic [NUM_REQ-1:0]       rsp_vld,
    input  logic [NUM_REQ-1:0]       rsp_rdy,
    output logic                     err
);

    localparam int TW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CW = $clog2(TAG_DEPTH + 1);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [TW-1:0]    tag_q;
    logic             a_pend;
    logic             b_pend;

    logic [TW-1:0]    tag_mem [TAG_DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;

    logic             issue_empty;
    logic             fifo_empty;
    logic             gnt_found;
    logic [TW-1:0]    gnt_idx;
    logic             grant;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             push;
    logic             pop;
    logic [TW-1:0]    head;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(TAG_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef ADD_ARB_PRIO_EN
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_vld[i]) begin
                gnt_found = 1'b1;
                gnt_idx   = TW'(i);
            end
        end
    end
`else
    logic [TW-1:0] ptr;

    function automatic logic [TW-1:0] wrap_idx(input logic [TW-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return TW'(sum);
    endfunction

    // Descending scan so the smallest offset from ptr wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_vld[wrap_idx(ptr, k)]) begin
                gnt_found = 1'b1;
                gnt_idx   = wrap_idx(ptr, k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant) begin
            ptr <= (gnt_idx == TW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end
`endif

    assign issue_empty = !a_pend && !b_pend;
    assign fifo_empty  = (count == '0);
    // Full test uses the registered count, so a same-cycle pop does not open a slot early.
    assign grant       = !rst && issue_empty && (count < CW'(TAG_DEPTH)) && gnt_found;

    always_comb begin
        req_rdy = '0;
        if (grant) req_rdy[gnt_idx] = 1'b1;
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == TW'(i)) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Issue register: each operand handshakes independently with the adder.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_pend <= 1'b0;
            b_pend <= 1'b0;
        end else if (grant) begin
            a_pend <= 1'b1;
            b_pend <= 1'b1;
        end else begin
            if (a_pend && add_a_rdy) a_pend <= 1'b0;
            if (b_pend && add_b_rdy) b_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (grant) begin
            a_q   <= sel_a;
            b_q   <= sel_b;
            tag_q <= gnt_idx;
        end
    end

    assign add_a     = a_q;
    assign add_b     = b_q;
    assign add_a_vld = a_pend;
    assign add_b_vld = b_pend;

    assign push = !issue_empty && (!a_pend || add_a_rdy) && (!b_pend || add_b_rdy);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= tag_q;
    end

    assign head  = tag_mem[rd_ptr];
    assign rsp_c = add_c;

    // With nothing in flight the adder output is drained so a stray result cannot stall it.
    always_comb begin
        rsp_vld   = '0;
        add_c_rdy = 1'b1;
        pop       = 1'b0;
        if (!fifo_empty) begin
            rsp_vld[head] = add_c_vld;
            add_c_rdy     = rsp_rdy[head];
            pop           = add_c_vld && rsp_rdy[head];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (fifo_empty && add_c_vld) begin
            err <= 1'b1;
        end
    end

endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 SHALL provide parameter NUM_REQ, default 4, number of requesters sharing one adder.
REQ-002 SHALL provide parameter WIDTH, default 32, operand and result width.
REQ-003 SHALL provide parameter TAG_DEPTH, default 4, the maximum number of operations in flight.
REQ-004 clk  in  1  clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req_a  in  NUM_REQ*WIDTH  operand A per requester, slice i = requester i.
REQ-007 req_b  in  NUM_REQ*WIDTH  operand B per requester.
REQ-008 req_vld  in  NUM_REQ  request valid per requester.
REQ-009 req_rdy  out  NUM_REQ  request accepted this cycle per requester.
REQ-010 add_a / add_b  out  WIDTH each  operands to the shared adder.
REQ-011 add_a_vld / add_b_vld  out  1 each  operand valids to the adder.
REQ-012 add_a_rdy / add_b_rdy  in  1 each  operand accepts from the adder; the two may assert in different cycles.
REQ-013 add_c  in  WIDTH  adder result; add_c_vld in 1; add_c_rdy out 1.
REQ-014 rsp_c  out  WIDTH  result bus shared by all requesters.
REQ-015 rsp_vld  out  NUM_REQ  one-hot result valid per requester; rsp_rdy in NUM_REQ.
REQ-016 err  out  1  sticky flag; set when the adder returns a result while no operation is in flight.

Function
REQ-017 The block SHALL hold one issue register (a_q, b_q, tag_q, a_pend, b_pend).
- It is empty when a_pend = b_pend = 0.
REQ-018 Arbitration SHALL occur only when:
- the issue register is empty, and
- the tag FIFO holds fewer than TAG_DEPTH entries.
Exactly one req_rdy[g] asserts, for the winning valid requester g, and a_q/b_q/tag_q load with a_pend = b_pend = 1 on the same edge.
REQ-019 Without ADD_ARB_PRIO_EN, the grant SHALL be round-robin.
- The winner is the first valid index at or after pointer ptr, searching upward with wrap-around.
- ptr becomes g+1 modulo NUM_REQ after each grant.
- ptr does not change when no grant occurs.
REQ-020 add_a_vld SHALL equal a_pend and add_b_vld SHALL equal b_pend; add_a = a_q and add_b = b_q.
REQ-021 a_pend SHALL clear on the cycle add_a_rdy is sampled high; b_pend SHALL clear on the cycle add_b_rdy is sampled high; the two are independent.
REQ-022 tag_q SHALL be pushed into the tag FIFO on the cycle the last pending operand is accepted, including when both are accepted in the same cycle.
REQ-023 A new grant SHALL be allowed no earlier than the cycle after the issue register empties, so grant-to-grant spacing is at least 2 cycles.
REQ-024 When the tag FIFO is non-empty, with head tag h:
- rsp_c = add_c;
- rsp_vld[h] = add_c_vld, and all other rsp_vld bits are 0;
- add_c_rdy = rsp_rdy[h];
- the FIFO pops when add_c_vld & rsp_rdy[h].
REQ-025 When the tag FIFO is empty:
- add_c_rdy SHALL be 1, so stray results are drained;
- rsp_vld SHALL be all zero;
- add_c_vld high SHALL set err.
REQ-026 A push and a pop in the same cycle SHALL leave the FIFO count unchanged.
- This is permitted when the FIFO is full; the full test for REQ-018 uses the pre-pop count.
REQ-027 Results SHALL return to requesters in issue order; operand arithmetic is performed entirely by the adder.
REQ-028 Adder back-pressure SHALL block only issue, never response routing.
- Requester back-pressure on rsp_rdy SHALL stall add_c_rdy only.

Reset
REQ-029 On rst, the block SHALL clear a_pend, b_pend, ptr, the FIFO read/write pointers and count, and err.
- All req_rdy, add_*_vld and rsp_vld outputs are 0 in the cycle after rst is sampled.
REQ-030 rst asserted mid-operation SHALL discard any pending issue and all in-flight tags.
- The adder is reset on the same rst net.

Configuration
REQ-031 Macro ADD_ARB_PRIO_EN:
- when defined, the grant SHALL be fixed priority (lowest valid index wins) and ptr is not implemented;
- when undefined, round-robin per REQ-019 applies.

Verification
REQ-032 Round-robin: req_vld = 4'b1111 held, adder always ready -> grants in order 0,1,2,3,0, each result 5+7 = 12 arrives on the granted requester's rsp_vld bit.
REQ-033 Split accept: add_a_rdy high at cycle t, add_b_rdy high at t+2 -> a single tag push at t+2, and no new req_rdy before t+3.
REQ-034 FIFO full: rsp_rdy = 0 with TAG_DEPTH = 4 -> exactly 4 issues, then req_rdy stays 0; one rsp_rdy pulse -> one pop and one new grant.
REQ-035 Ordering: requester 2 adds 1+1, then requester 0 adds 0xFFFFFFFF+1 -> rsp_vld[2] with 2 first, then rsp_vld[0] with 0.
REQ-036 Reset mid-flight: rst with 2 tags queued -> the FIFO is empty, err = 0, a late add_c_vld is drained and sets err = 1.
REQ-037 With ADD_ARB_PRIO_EN defined: req_vld = 4'b1010 held -> requester 1 is always granted and requester 3 is starved.
